muldiv_seq: RTL

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 32-step multiply/divide unit with a MIPS-style hi/lo result pair.
// A request latched in IDLE passes through PREP, RUN and FIX, then a one-cycle DONE.
// PREP converts signed operands to magnitudes. RUN runs one shift-add or
// restoring shift-subtract step per cycle. FIX restores the signs.
//
// Ports:
//   clk      - single clock, rising-edge active
//   rst_n    - asynchronous active-low reset
//   start    - operation request, honoured only in IDLE
//   op       - op[1]: 0 multiply / 1 divide, op[0]: 0 unsigned / 1 signed
//   abort    - synchronous cancel, returns to IDLE without touching hi/lo/div_zero
//   rs_data  - multiplicand / dividend
//   rt_data  - multiplier / divisor
//   busy     - high whenever the unit is not IDLE
//   done     - one-cycle pulse when hi/lo are written
//   hi       - product upper word or remainder
//   lo       - product lower word or quotient
//   div_zero - set when the most recent completed operation was a divide by zero

module muldiv_seq #(
    parameter int word_size = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic                 abort,
    input  logic [word_size-1:0] rs_data,
    input  logic [word_size-1:0] rt_data,
    output logic                 busy,
    output logic                 done,
    output logic [word_size-1:0] hi,
    output logic [word_size-1:0] lo,
    output logic                 div_zero
);

    localparam int W  = word_size;
    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

    state_t         state;
    logic [CW-1:0]  count;
    logic [1:0]     op_r;
    logic [W-1:0]   a_raw;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   acc;
    logic [W-1:0]   lo_work;
    logic           neg_res;
    logic           neg_rem;
    logic           dz;

    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic           div_ge;
    logic [W-1:0]   div_diff;
    logic [2*W-1:0] prod_neg;
    logic [W-1:0]   fix_hi;
    logic [W-1:0]   fix_lo;

    // b_reg holds the raw divisor/multiplier only while in PREP; from RUN on it holds the magnitude.
    // The W+1-bit compare is wide enough for the shifted partial remainder, which can reach 2*divisor-1.
    always_comb begin
        a_neg     = op_r[0] & a_raw[W-1];
        b_neg     = op_r[0] & b_reg[W-1];
        a_mag     = a_neg ? -a_raw : a_raw;
        b_mag     = b_neg ? -b_reg : b_reg;
        mul_sum   = {1'b0, acc} + (lo_work[0] ? {1'b0, b_reg} : '0);
        div_shift = {acc, lo_work[W-1]};
        div_ge    = (div_shift >= {1'b0, b_reg});
        div_diff  = div_shift[W-1:0] - b_reg;
        prod_neg  = -{acc, lo_work};
        fix_hi    = acc;
        fix_lo    = lo_work;
        if (op_r[1]) begin
            if (neg_res) fix_lo = -lo_work;
            if (neg_rem) fix_hi = -acc;
        end else if (neg_res) begin
            fix_hi = prod_neg[2*W-1:W];
            fix_lo = prod_neg[W-1:0];
        end
    end

    // A zero divisor is routed PREP -> FIX -> DONE so that done comes two edges after acceptance.
    // FIX then writes the trap result instead of a sign-corrected one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            op_r     <= '0;
            a_raw    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            lo_work  <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            op_r  <= op;
                            a_raw <= rs_data;
                            b_reg <= rt_data;
                            busy  <= 1'b1;
                            state <= PREP;
                        end
                    end
                    PREP: begin
                        acc     <= '0;
                        lo_work <= a_mag;
                        b_reg   <= b_mag;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        count   <= '0;
                        if (op_r[1] && b_reg == '0) begin
                            dz    <= 1'b1;
                            state <= FIX;
                        end else begin
                            dz    <= 1'b0;
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (op_r[1]) begin
                            if (div_ge) begin
                                acc     <= div_diff;
                                lo_work <= {lo_work[W-2:0], 1'b1};
                            end else begin
                                acc     <= div_shift[W-1:0];
                                lo_work <= {lo_work[W-2:0], 1'b0};
                            end
                        end else begin
                            acc     <= mul_sum[W:1];
                            lo_work <= {mul_sum[0], lo_work[W-1:1]};
                        end
                        count <= count + CW'(1);
                        if (count == CW'(W - 1)) state <= FIX;
                    end
                    FIX: begin
                        if (dz) begin
                            hi       <= a_raw;
                            lo       <= '1;
                            div_zero <= 1'b1;
                        end else begin
                            hi       <= fix_hi;
                            lo       <= fix_lo;
                            div_zero <= 1'b0;
                        end
                        done  <= 1'b1;
                        state <= DONE;
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
